// File: rtl/sqrt_display.sv
// Four-digit multiplexed seven-segment driver: shows operand a in decimal and
// its square root as one hex digit, with a sequential double-dabble converter.
module sqrt_display #(
  parameter int DIV_BITS = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] a,
  input  logic [3:0] sqrt,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t              r_state, w_next;
  logic [DIV_BITS-1:0] r_cnt;
  logic [7:0]          r_a_last, r_a_lat, r_shift;
  logic [11:0]         r_bcd;
  logic [2:0]          r_bit;
  logic [3:0]          r_hund, r_tens, r_ones;
  logic [3:0]          r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                w_load, w_step, w_write;
  logic [1:0]          w_idx;
  logic [11:0]         w_adj;
  logic [3:0]          w_digit;
  logic                w_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (a != r_a_last) w_next = CONV;
      CONV:    if (r_bit == 3'd7) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load  = (r_state == IDLE) && (a != r_a_last);
    w_step  = (r_state == CONV);
    w_write = (r_state == UPDATE);
  end

  assign w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  // a is sampled only on load, so changes during CONV cannot corrupt the shifter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_a_lat  <= '0;
      r_a_last <= '0;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_bit    <= '0;
      r_hund   <= '0;
      r_tens   <= '0;
      r_ones   <= '0;
    end else begin
      if (w_load) begin
        r_a_lat <= a;
        r_shift <= a;
        r_bcd   <= '0;
        r_bit   <= '0;
      end else if (w_step) begin
        {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
        r_bit            <= r_bit + 3'd1;
      end
      if (w_write) begin
        r_hund   <= r_bcd[11:8];
        r_tens   <= r_bcd[7:4];
        r_ones   <= r_bcd[3:0];
        r_a_last <= r_a_lat;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_cnt <= '0;
    else     r_cnt <= r_cnt + DIV_BITS'(1);
  end

  assign w_idx = r_cnt[DIV_BITS-1 -: 2];

  always_comb begin
    w_digit = sqrt;
    w_blank = 1'b0;
    case (w_idx)
      2'd1: w_digit = r_ones;
      2'd2: begin
        w_digit = r_tens;
        w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
      end
      2'd3: begin
        w_digit = r_hund;
        w_blank = (r_hund == 4'd0);
      end
      default: w_digit = sqrt;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << w_idx);
      r_seg <= w_blank ? 7'b1111111 : hex_seg(w_digit);
      r_dp  <= (w_idx != 2'd1);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_sqrt_display.sv
// Scoreboard bench for sqrt_display with a 16-cycle scan (DIV_BITS=4).
module tb_sqrt_display;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] a;
  logic [3:0] sqrt;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  d;
    logic [11:0] v;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_cnt;
  logic [1:0] m_idx;
  logic       m_act;

  sqrt_display #(.DIV_BITS(4)) dut (
    .clk (clk),
    .clr (clr),
    .a   (a),
    .sqrt(sqrt),
    .an  (an),
    .seg (seg),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  // reference scan position: which digit the registered outputs show
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_cnt <= 4'd0;
      m_idx <= 2'd0;
      m_act <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
      m_idx <= m_cnt[3:2];
      m_act <= 1'b1;
    end
  end

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  function automatic logic [11:0] exp_for(input int d, input int av, input int sv);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    an_e  = ~(4'b0001 << d);
    dp_e  = (d != 1);
    case (d)
      0: seg_e = ref_seg(sv);
      1: seg_e = ref_seg(av % 10);
      2: seg_e = (av < 10) ? 7'h7F : ref_seg((av / 10) % 10);
      default: seg_e = (av < 100) ? 7'h7F : ref_seg(av / 100);
    endcase
    return {an_e, seg_e, dp_e};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got an/seg/dp=%h, expected %h", tag, obs, exp);
  endtask

  task automatic push_scan(input int av, input int sv);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.d = 2'(d);
      e.v = exp_for(d, av, sv);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    bit   found;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      found = 0;
      for (int n = 0; n < 40; n++) begin
        if (m_act && m_idx == e.d) begin
          found = 1;
          break;
        end
        @(negedge clk);
      end
      if (!found) check_eq({tag, "_timeout"}, {11'd0, found}, 12'd1);
      check_eq($sformatf("%s_d%0d", tag, e.d), {an, seg, dp}, e.v);
      @(negedge clk);
    end
  endtask

  task automatic check_cur(input string tag, input int av, input int sv);
    check_eq($sformatf("%s_d%0d", tag, m_idx), {an, seg, dp}, exp_for(int'(m_idx), av, sv));
  endtask

  initial begin
    clr  = 1'b1;
    a    = 8'd0;
    sqrt = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("reset", {an, seg, dp}, 12'hFFF);

    clr = 1'b0;
    @(negedge clk);
    check_eq("scan_start", {an, seg, dp}, exp_for(0, 0, 0));
    push_scan(0, 0);
    drain("zero");

    // 255 / 15: display must be current 11 edges after the change
    a = 8'd255; sqrt = 4'd15;
    repeat (11) @(negedge clk);
    check_cur("lat255", 255, 15);
    push_scan(255, 15);
    drain("a255");

    a = 8'd100; sqrt = 4'd10;
    repeat (11) @(negedge clk);
    push_scan(100, 10);
    drain("a100");

    a = 8'd9; sqrt = 4'd3;
    repeat (11) @(negedge clk);
    push_scan(9, 3);
    drain("a9");

    // 200 then 17 arriving during the third CONV cycle
    a = 8'd200; sqrt = 4'd4;
    repeat (3) @(negedge clk);
    a = 8'd17;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_cur("a200_first", 200, 4);
      @(negedge clk);
    end
    push_scan(17, 4);
    drain("a17");

    // reset pulse in the middle of a conversion of 64
    a = 8'd64; sqrt = 4'd8;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    check_eq("clr_async", {an, seg, dp}, 12'hFFF);
    @(negedge clk);
    check_eq("clr_hold", {an, seg, dp}, 12'hFFF);
    clr = 1'b0;
    @(negedge clk);
    check_eq("rel_d0", {an, seg, dp}, exp_for(0, 64, 8));
    repeat (10) @(negedge clk);
    push_scan(64, 8);
    drain("a64");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sqrt_display.md
SQRT_DISPLAY -- requirements
Module: sqrt_display

Interface
REQ-001 Parameter DIV_BITS, default 17, width of the free-running refresh counter; legal range 4..24.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 a  input  8  unsigned operand fed to the square-root unit; displayed in decimal.
REQ-005 sqrt  input  4  result from the square-root unit; displayed as one hex digit.
REQ-006 an  output  4  active-low digit enables; an[0] rightmost.
REQ-007 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-008 dp  output  1  active-low decimal point.

Function
REQ-009 Digit map SHALL be: an[0] = sqrt (hex 0-F), an[1] = ones of a, an[2] = tens of a, an[3] = hundreds of a.
REQ-010 Refresh counter SHALL increment every cycle, wrap at 2^DIV_BITS-1 -> 0, and supply the digit index cnt[DIV_BITS-1:DIV_BITS-2], scanning 0,1,2,3 and wrapping.
REQ-011 an, seg and dp SHALL be registered and SHALL reflect the digit index with exactly one cycle of latency.
REQ-012 Exactly one an bit SHALL be low outside reset.
REQ-013 dp SHALL be low only while digit 1 is selected, forming the separator between a and sqrt.
REQ-014 Segment codes (seg) SHALL be: 0=1000000, 1=1111001, 2=0100100, 5=0010010, 7=1111000, 9=0010000, F=0001110, blank=1111111; all remaining hex digits use standard encoding.
REQ-015 Leading-zero blanking:
- hundreds SHALL be blank when 0;
- tens SHALL be blank when hundreds and tens are both 0;
- ones and the sqrt digit SHALL never be blanked.
REQ-016 Binary-to-BCD conversion SHALL be sequential shift-add-3 (double dabble) through an FSM with states IDLE, CONV and UPDATE.
REQ-017 IDLE: when a != a_last, latch a into the shifter, clear the BCD scratch and go to CONV; otherwise stay in IDLE.
REQ-018 CONV SHALL last exactly 8 cycles, each cycle adding 3 to every BCD nibble >= 5 and then shifting left by one.
REQ-019 UPDATE SHALL last 1 cycle, write the hundreds/tens/ones display registers and a_last (set to the latched value), then return to IDLE.
REQ-020 Display digits SHALL update no later than 10 rising edges after a changes, provided a is stable.
REQ-021 A change of a during CONV SHALL NOT disturb the running conversion; that conversion SHALL complete and display, then IDLE SHALL detect the mismatch and reconvert.
REQ-022 sqrt SHALL be displayed directly through the registered output path, with no conversion latency.
REQ-023 Hundreds SHALL never exceed 2; each BCD nibble SHALL remain within 0-9.

Reset
REQ-024 While clr is high, an=1111, seg=1111111, dp=1, refresh counter=0, FSM=IDLE, all BCD registers=0 and a_last=0.
REQ-025 clr asserted mid-conversion SHALL abort the conversion immediately, with no partial write to the display registers.
REQ-026 After clr falls, scanning SHALL begin with digit 0, and any nonzero a SHALL start a fresh conversion.

Verification (DIV_BITS=4, 4 cycles per digit)
REQ-027 Reset: with clr=1, a=0, sqrt=0 -> an=1111, seg=1111111, dp=1. After release, the scan SHALL show:
- digit0 = 1000000;
- digit1 = 1000000 with dp=0;
- digits 2 and 3 = blank.
REQ-028 a=255, sqrt=15 -> within 10 cycles, digits 3..0 SHALL show 2 (0100100), 5, 5 (0010010) and F (0001110).
REQ-029 a=100, sqrt=10 -> digits 3..0 SHALL show 1, 0, 0, A; the tens 0 SHALL NOT be blanked.
REQ-030 a=9, sqrt=3 -> digits 3 and 2 blank, digit1 = 9 (0010000), digit0 = 3.
REQ-031 a changes 200 -> 17 on the 3rd CONV cycle -> the display SHALL first show 200 and then show 17 (1111001, 1111000 on digits 2 and 1, hundreds blank) within 20 cycles of the change.
REQ-032 clr pulsed for 1 cycle during CONV with a=64 -> the display returns to its reset state, then shows 64 within 10 cycles of release.
